voice_alloc: RTL and testbench

Polyphonic voice allocator between the MIDI decoder and the oscillator stack. Each note-on strobe is assigned to a specific voice slot, and the note is stored per voice. Each note-off strobe releases the slot that holds that note. When every slot is busy, a parameter selects the policy: steal the oldest voice, or drop the new note. This replaces the count-based enable scheme, in which a note-off always released the highest voice and every voice shared one note value.

---
 rtl/voice_alloc.sv | 132 +++++++++++++
 tb/tb_voice_alloc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/note-off strobes onto voice slots,
// tracks per-voice note and age (0 = newest), and steals the oldest voice or
// drops the new note when every slot is busy.
module voice_alloc #(
  parameter int VOICES = 4,
  parameter int NOTE_W = 8,
  parameter int STEAL  = 1
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic [NOTE_W-1:0]             note_i,
  input  logic                          noteOnStrb_i,
  input  logic                          noteOffStrb_i,
  input  logic                          allOff_i,
  output logic [VOICES*NOTE_W-1:0]      voiceNote_o,
  output logic [VOICES-1:0]             voiceEn_o,
  output logic [$clog2(VOICES+1)-1:0]   activeCount_o,
  output logic                          stealStrb_o,
  output logic                          dropStrb_o
);

  localparam int AW = $clog2(VOICES);
  localparam int CW = $clog2(VOICES+1);

  logic [VOICES-1:0]             r_active, w_active_next;
  logic [VOICES-1:0][NOTE_W-1:0] r_note, w_note_next;
  logic [VOICES-1:0][AW-1:0]     r_age, w_age_next;
  logic [CW-1:0]                 r_count, w_count_next;
  logic                          r_steal, w_steal_next;
  logic                          r_drop, w_drop_next;

  logic [VOICES-1:0] w_match;
  logic              w_hit;
  logic              w_full;
  logic [AW-1:0]     w_hit_idx, w_hit_age, w_free_idx, w_old_idx, w_target;

  // An active slot matches when it holds the incoming note; retrigger keeps this one-hot.
  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_match
      assign w_match[gi] = r_active[gi] && (r_note[gi] == note_i);
    end
  endgenerate

  assign w_hit     = |w_match;
  assign w_full    = (r_count == CW'(VOICES));
  assign w_hit_age = r_age[w_hit_idx];

  // Locate the matching slot, the lowest-index free slot and the oldest active slot.
  always_comb begin
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_old_idx  = '0;
    for (int k = VOICES-1; k >= 0; k--) begin
      if (w_match[k]) w_hit_idx = AW'(k);
      if (!r_active[k]) w_free_idx = AW'(k);
      if (r_active[k] && (r_age[k] == AW'(VOICES-1))) w_old_idx = AW'(k);
    end
  end

  // Next-state: one event per cycle, allOff over note-on over note-off.
  always_comb begin
    w_active_next = r_active;
    w_note_next   = r_note;
    w_age_next    = r_age;
    w_count_next  = r_count;
    w_steal_next  = 1'b0;
    w_drop_next   = 1'b0;
    w_target      = w_full ? w_old_idx : w_free_idx;
    if (allOff_i) begin
      w_active_next = '0;
      w_age_next    = '0;
      w_count_next  = '0;
    end else if (noteOnStrb_i) begin
      if (w_hit) begin
        // Retrigger: the held voice becomes newest, younger voices age by one.
        for (int k = 0; k < VOICES; k++) begin
          if (r_active[k]) begin
            if (AW'(k) == w_hit_idx) w_age_next[k] = '0;
            else if (r_age[k] < w_hit_age) w_age_next[k] = r_age[k] + AW'(1);
          end
        end
      end else if (!w_full || (STEAL != 0)) begin
        // New allocation (free slot or stolen oldest slot); everyone else ages.
        for (int k = 0; k < VOICES; k++) begin
          if (r_active[k] && (AW'(k) != w_target)) w_age_next[k] = r_age[k] + AW'(1);
        end
        w_active_next[w_target] = 1'b1;
        w_note_next[w_target]   = note_i;
        w_age_next[w_target]    = '0;
        if (w_full) w_steal_next = 1'b1;
        else        w_count_next = r_count + CW'(1);
      end else begin
        w_drop_next = 1'b1;
      end
    end else if (noteOffStrb_i && w_hit) begin
      // Release: voices older than the released one close the gap.
      for (int k = 0; k < VOICES; k++) begin
        if (r_active[k] && (r_age[k] > w_hit_age)) w_age_next[k] = r_age[k] - AW'(1);
      end
      w_active_next[w_hit_idx] = 1'b0;
      w_age_next[w_hit_idx]    = '0;
      w_count_next             = r_count - CW'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_active <= '0;
      r_note   <= '0;
      r_age    <= '0;
      r_count  <= '0;
      r_steal  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_active <= w_active_next;
      r_note   <= w_note_next;
      r_age    <= w_age_next;
      r_count  <= w_count_next;
      r_steal  <= w_steal_next;
      r_drop   <= w_drop_next;
    end
  end

  assign voiceNote_o   = r_note;
  assign voiceEn_o     = r_active;
  assign activeCount_o = r_count;
  assign stealStrb_o   = r_steal;
  assign dropStrb_o    = r_drop;

endmodule

// File: tb/tb_voice_alloc.sv
// Randomized + directed bench for voice_alloc. Reference model keeps voices in
// an age-ordered queue (front = newest); ages are queue positions.
module tb_voice_alloc;

  localparam int V  = 4;
  localparam int NW = 8;
  localparam int CW = $clog2(V+1);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [NW-1:0] note = '0;
  logic          on = 1'b0, off = 1'b0, alloff = 1'b0;

  logic [V*NW-1:0] vnote, vnote_d;
  logic [V-1:0]    ven, ven_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            steal, steal_d, drop, drop_d;

  voice_alloc #(.VOICES(V), .NOTE_W(NW), .STEAL(1)) dut (
    .clk_i(clk), .nrst_i(nrst), .note_i(note), .noteOnStrb_i(on),
    .noteOffStrb_i(off), .allOff_i(alloff), .voiceNote_o(vnote),
    .voiceEn_o(ven), .activeCount_o(cnt), .stealStrb_o(steal), .dropStrb_o(drop));

  voice_alloc #(.VOICES(V), .NOTE_W(NW), .STEAL(0)) dut_drop (
    .clk_i(clk), .nrst_i(nrst), .note_i(note), .noteOnStrb_i(on),
    .noteOffStrb_i(off), .allOff_i(alloff), .voiceNote_o(vnote_d),
    .voiceEn_o(ven_d), .activeCount_o(cnt_d), .stealStrb_o(steal_d), .dropStrb_o(drop_d));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  // reference model for the STEAL=1 instance
  bit m_act[V];
  int m_note[V];
  int ord[$];
  bit m_st, m_dr;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find_held(input int n);
    for (int k = 0; k < V; k++) if (m_act[k] && m_note[k] == n) return k;
    return -1;
  endfunction

  function automatic int m_age(input int k);
    if (!m_act[k]) return 0;
    for (int i = 0; i < ord.size(); i++) if (ord[i] == k) return i;
    return 0;
  endfunction

  task automatic q_remove(input int v);
    for (int i = 0; i < ord.size(); i++)
      if (ord[i] == v) begin ord.delete(i); return; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < V; k++) begin m_act[k] = 0; m_note[k] = 0; end
    ord.delete();
    m_st = 0; m_dr = 0;
  endtask

  task automatic model_step(input bit s_on, input bit s_off, input bit s_all, input int n);
    int h, t;
    m_st = 0; m_dr = 0;
    h = find_held(n);
    if (s_all) begin
      for (int k = 0; k < V; k++) m_act[k] = 0;
      ord.delete();
    end else if (s_on) begin
      if (h >= 0) begin
        q_remove(h); ord.push_front(h);
      end else if (ord.size() < V) begin
        t = 0;
        while (m_act[t]) t++;
        m_act[t] = 1; m_note[t] = n; ord.push_front(t);
      end else begin
        t = ord[$];
        ord.pop_back();
        m_note[t] = n; ord.push_front(t); m_st = 1;
      end
    end else if (s_off && h >= 0) begin
      m_act[h] = 0; q_remove(h);
    end
  endtask

  function automatic int vn(input int k);
    return int'(vnote[k*NW +: NW]);
  endfunction

  // per-cycle comparison of the STEAL=1 instance against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [V-1:0] e;
      for (int k = 0; k < V; k++) e[k] = m_act[k];
      chk("en", int'(ven), int'(e));
      chk("count", int'(cnt), ord.size());
      chk("steal", int'(steal), int'(m_st));
      chk("drop", int'(drop), 0);
      for (int k = 0; k < V; k++) begin
        chk($sformatf("note%0d", k), vn(k), m_note[k]);
        chk($sformatf("age%0d", k), int'(dut.r_age[k]), m_age(k));
      end
    end
  end

  // one strobe cycle: drive, let the edge sample it, update model, return to idle
  task automatic ev(input bit s_on, input bit s_off, input bit s_all, input int n);
    on = s_on; off = s_off; alloff = s_all; note = NW'(n);
    @(posedge clk);
    model_step(s_on, s_off, s_all, n);
    #1;
    on = 0; off = 0; alloff = 0;
  endtask

  task automatic peek();
    @(negedge clk); #1;
  endtask

  task automatic mid_reset();
    #2;
    nrst = 0;
    model_reset();
    #1;
    chk("rst_en", int'(ven), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_steal", int'(steal), 0);
    chk("rst_drop", int'(drop_d), 0);
    chk("rst_notes", int'(vnote), 0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1;
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    cmp_en = 1;
    #1;
    chk("init_en", int'(ven), 0);
    chk("init_cnt", int'(cnt), 0);
    chk("init_notes", int'(vnote), 0);
    @(negedge clk); nrst = 1; #1;

    // three notes back to back
    ev(1,0,0,60); ev(1,0,0,64); ev(1,0,0,67); peek();
    chk("t1_en", int'(ven), 4'b0111);
    chk("t1_n0", vn(0), 60); chk("t1_n1", vn(1), 64); chk("t1_n2", vn(2), 67);
    chk("t1_a0", int'(dut.r_age[0]), 2); chk("t1_a1", int'(dut.r_age[1]), 1);
    chk("t1_a2", int'(dut.r_age[2]), 0); chk("t1_cnt", int'(cnt), 3);

    // release then reuse voice 1
    ev(0,1,0,64); ev(1,0,0,72); peek();
    chk("t2_en", int'(ven), 4'b0111); chk("t2_n1", vn(1), 72);
    chk("t2_a0", int'(dut.r_age[0]), 2); chk("t2_a2", int'(dut.r_age[2]), 1);
    chk("t2_a1", int'(dut.r_age[1]), 0);

    // full pool: steal on one instance, drop on the other
    ev(0,0,1,0);
    ev(1,0,0,60); ev(1,0,0,62); ev(1,0,0,64); ev(1,0,0,65);
    ev(1,0,0,67); peek();
    chk("t3_steal", int'(steal), 1); chk("t3_n0", vn(0), 67); chk("t3_cnt", int'(cnt), 4);
    chk("t3_drop", int'(drop_d), 1); chk("t3_dsteal", int'(steal_d), 0);
    chk("t3_dn0", int'(vnote_d[0 +: NW]), 60); chk("t3_dcnt", int'(cnt_d), 4);
    ev(0,0,0,0); peek();
    chk("t3_steal_end", int'(steal), 0); chk("t3_drop_end", int'(drop_d), 0);

    // retrigger
    ev(0,0,1,0);
    ev(1,0,0,60); ev(1,0,0,62); ev(1,0,0,64); ev(1,0,0,60); peek();
    chk("t4_cnt", int'(cnt), 3); chk("t4_a0", int'(dut.r_age[0]), 0);
    chk("t4_a1", int'(dut.r_age[1]), 2); chk("t4_a2", int'(dut.r_age[2]), 1);

    // simultaneous on/off: on wins; off of unheld note is ignored
    ev(1,1,0,50); peek();
    chk("t5_en", int'(ven), 4'b1111); chk("t5_n3", vn(3), 50); chk("t5_cnt", int'(cnt), 4);
    ev(0,1,0,99); peek();
    chk("t5b_en", int'(ven), 4'b1111); chk("t5b_cnt", int'(cnt), 4);

    // panic with three voices active; note registers keep their values
    ev(0,1,0,50); ev(0,0,1,0); peek();
    chk("t6_en", int'(ven), 0); chk("t6_cnt", int'(cnt), 0); chk("t6_n3", vn(3), 50);

    // reset in the middle of a burst
    ev(1,0,0,70); ev(1,0,0,71);
    mid_reset();
    ev(1,0,0,80); peek();
    chk("t7_en", int'(ven), 4'b0001); chk("t7_n0", vn(0), 80);

    // randomized traffic on a small note range so hits are frequent
    for (int i = 0; i < 1500; i++) begin
      int r, n;
      r = $urandom_range(0, 99);
      n = 40 + $urandom_range(0, 7);
      if (r < 1)       mid_reset();
      else if (r < 4)  ev(0,0,1,0);
      else if (r < 50) ev(1,0,0,n);
      else if (r < 85) ev(0,1,0,n);
      else if (r < 90) ev(1,1,0,n);
      else             ev(0,0,0,n);
    end
    peek();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
